// File: rtl/motor_ramp_pkg.sv
// motor_ramp_pkg
// Shared types, default widths and the duty-step helper for the motor ramp
// sequencer.
// Contents:
//   ramp_state_e       sequencer state. FAULT exists only when
//                      MOTOR_RAMP_FAULT_EN is defined.
//   DEF_DUTY_W         default width of duty values and step size
//   DEF_PRESC_W        default width of the step-period prescaler
//   DEF_DT_W           default width of the dead-time counter
//   duty_step_toward   moves a duty value one step toward a goal and clamps
//                      the result at the goal
package motor_ramp_pkg;

  localparam int DEF_DUTY_W  = 16;
  localparam int DEF_PRESC_W = 16;
  localparam int DEF_DT_W    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    DEAD  = 3'd2,
`ifdef MOTOR_RAMP_FAULT_EN
    HOLD  = 3'd3,
    FAULT = 3'd4
`else
    HOLD  = 3'd3
`endif
  } ramp_state_e;

  // Callers zero-extend their operands to 32 bits. The sum is formed in
  // 33 bits, so an upward step near full scale clamps at the goal and cannot
  // wrap. A step of 0 means "jump straight to the goal".
  function automatic logic [31:0] duty_step_toward(
    input logic [31:0] cur,
    input logic [31:0] goal,
    input logic [31:0] step
  );
    logic [32:0] sum;
    logic [31:0] gap;
    logic [31:0] res;
    sum = {1'b0, cur} + {1'b0, step};
    gap = cur - goal;
    if (step == 32'd0) begin
      res = goal;
    end else if (cur < goal) begin
      if (sum >= {1'b0, goal}) begin
        res = goal;
      end else begin
        res = sum[31:0];
      end
    end else begin
      if (step >= gap) begin
        res = goal;
      end else begin
        res = cur - step;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/motor_ramp_sequencer_if.sv
// motor_ramp_sequencer_if
// Command handshake between the register bank (master) and the ramp
// sequencer (slave).
// Signals:
//   cmd_valid  master offers a new command
//   cmd_ready  slave can accept a command
//   cmd_duty   target duty magnitude
//   cmd_dir    target direction
interface motor_ramp_sequencer_if #(
  parameter int DUTY_W = motor_ramp_pkg::DEF_DUTY_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DUTY_W-1:0] cmd_duty;
  logic              cmd_dir;

  modport master (
    output cmd_valid,
    output cmd_duty,
    output cmd_dir,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_duty,
    input  cmd_dir,
    output cmd_ready
  );

endinterface

// File: rtl/motor_ramp_prescaler.sv
// motor_ramp_prescaler
// Step-rate divider for the ramp sequencer. While enabled, the counter runs
// 0..max(period,1)-1 and tick is high on the terminal count.
// Ports:
//   ACLK     clock, rising edge
//   ARESET   synchronous active-high reset
//   clear    restart the count from 0 on the next edge
//   enable   count while high; the counter is held at 0 otherwise
//   period   cycles per tick; 0 behaves as 1
//   tick     one-cycle pulse on the terminal count
module motor_ramp_prescaler #(
  parameter int PRESC_W = motor_ramp_pkg::DEF_PRESC_W
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               clear,
  input  logic               enable,
  input  logic [PRESC_W-1:0] period,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_r;
  logic [PRESC_W-1:0] last_s;

  // The >= compare means a period shortened below the current count ticks
  // at once, instead of wrapping through the full counter range.
  assign last_s = (period == {PRESC_W{1'b0}}) ? {PRESC_W{1'b0}}
                                              : period - {{(PRESC_W-1){1'b0}}, 1'b1};
  assign tick   = enable && (cnt_r >= last_s);

  // Count register: restarts on clear, when disabled, and after each tick.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_r <= {PRESC_W{1'b0}};
    end else if (clear || !enable || tick) begin
      cnt_r <= {PRESC_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/motor_ramp_sequencer.sv
// motor_ramp_sequencer
// Takes target duty/direction commands from the register bank and moves the
// applied PWM duty toward the target in fixed steps at a programmable rate.
// Before any direction reversal it holds a zero-duty dead time.
// Optional feature: define MOTOR_RAMP_FAULT_EN to add the fault/fault_clr
// ports and the latched FAULT state. Without it, fault_flag is tied low.
// Ports:
//   ACLK, ARESET   clock; synchronous active-high reset
//   cmd_if         command handshake (slave side)
//   stop           ramp to zero duty and keep the current target direction
//   step_size      duty change per step; 0 jumps straight to the goal
//   step_period    ACLK cycles per step; 0 behaves as 1
//   dead_time      cycles held disabled before a direction flip (min 1)
//   fault          external fault (MOTOR_RAMP_FAULT_EN only)
//   fault_clr      clears a latched fault (MOTOR_RAMP_FAULT_EN only)
//   pwm_duty       applied duty
//   pwm_dir        applied direction
//   pwm_en         PWM output enable
//   busy           ramp or dead time in progress
//   at_target      applied duty and direction equal the target
//   fault_flag     fault latched
module motor_ramp_sequencer
  import motor_ramp_pkg::*;
#(
  parameter int DUTY_W  = DEF_DUTY_W,
  parameter int PRESC_W = DEF_PRESC_W,
  parameter int DT_W    = DEF_DT_W
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  motor_ramp_sequencer_if.slave cmd_if,
  input  logic                  stop,
  input  logic [DUTY_W-1:0]     step_size,
  input  logic [PRESC_W-1:0]    step_period,
  input  logic [DT_W-1:0]       dead_time,
`ifdef MOTOR_RAMP_FAULT_EN
  input  logic                  fault,
  input  logic                  fault_clr,
`endif
  output logic [DUTY_W-1:0]     pwm_duty,
  output logic                  pwm_dir,
  output logic                  pwm_en,
  output logic                  busy,
  output logic                  at_target,
  output logic                  fault_flag
);

  ramp_state_e       state_r;
  ramp_state_e       state_nxt_s;
  ramp_state_e       settled_s;
  logic [DUTY_W-1:0] pwm_duty_r;
  logic [DUTY_W-1:0] duty_nxt_s;
  logic [DUTY_W-1:0] target_duty_r;
  logic [DUTY_W-1:0] t_duty_nxt_s;
  logic [DUTY_W-1:0] goal_s;
  logic [DUTY_W-1:0] stepped_s;
  logic              pwm_dir_r;
  logic              dir_nxt_s;
  logic              target_dir_r;
  logic              t_dir_nxt_s;
  logic [DT_W-1:0]   dead_cnt_r;
  logic [DT_W-1:0]   dead_cnt_nxt_s;
  logic [DT_W-1:0]   dt_last_s;
  logic              pwm_en_r;
  logic              busy_r;
  logic              at_target_r;
  logic              cmd_ready_r;
  logic              accept_s;
  logic              matches_s;
  logic              reverse_wait_s;
  logic              tick_s;
  logic              presc_clr_s;
  logic              presc_en_s;

  // A stop in the same cycle as a command drops the command.
  assign accept_s = cmd_if.cmd_valid && cmd_ready_r && !stop;

  // Next target: fault clears the duty, stop zeroes it, an accepted command
  // replaces duty and direction.
  always_comb begin
    t_duty_nxt_s = target_duty_r;
    t_dir_nxt_s  = target_dir_r;
`ifdef MOTOR_RAMP_FAULT_EN
    if (fault || (state_r == FAULT)) begin
      t_duty_nxt_s = {DUTY_W{1'b0}};
    end else
`endif
    if (stop) begin
      t_duty_nxt_s = {DUTY_W{1'b0}};
    end else if (accept_s) begin
      t_duty_nxt_s = cmd_if.cmd_duty;
      t_dir_nxt_s  = cmd_if.cmd_dir;
    end else begin
      t_duty_nxt_s = target_duty_r;
      t_dir_nxt_s  = target_dir_r;
    end
  end

  // A pending direction change drives the duty to zero before the new target.
  assign goal_s = ((t_dir_nxt_s != pwm_dir_r) && (pwm_duty_r != {DUTY_W{1'b0}}))
                  ? {DUTY_W{1'b0}} : t_duty_nxt_s;

  assign stepped_s = DUTY_W'(duty_step_toward(32'(pwm_duty_r), 32'(goal_s),
                                              32'(step_size)));

  assign matches_s      = (pwm_duty_r == t_duty_nxt_s) && (pwm_dir_r == t_dir_nxt_s);
  assign settled_s      = (t_duty_nxt_s != {DUTY_W{1'b0}}) ? HOLD : IDLE;
  assign reverse_wait_s = (pwm_duty_r == {DUTY_W{1'b0}}) && (t_dir_nxt_s != pwm_dir_r);
  assign dt_last_s      = (dead_time == {DT_W{1'b0}}) ? {DT_W{1'b0}}
                                                      : dead_time - {{(DT_W-1){1'b0}}, 1'b1};

  // The prescaler runs only in RAMP; a new command restarts the step period.
  assign presc_en_s  = (state_r == RAMP);
  assign presc_clr_s = accept_s && (state_r == RAMP);

  motor_ramp_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .clear  (presc_clr_s),
    .enable (presc_en_s),
    .period (step_period),
    .tick   (tick_s)
  );

  // Next state, duty, direction and dead-time count.
  always_comb begin
    state_nxt_s    = state_r;
    duty_nxt_s     = pwm_duty_r;
    dir_nxt_s      = pwm_dir_r;
    dead_cnt_nxt_s = dead_cnt_r;
`ifdef MOTOR_RAMP_FAULT_EN
    if (fault) begin
      state_nxt_s    = FAULT;
      duty_nxt_s     = {DUTY_W{1'b0}};
      dead_cnt_nxt_s = {DT_W{1'b0}};
    end else begin
`endif
    case (state_r)
      IDLE, HOLD: begin
        if ((accept_s || stop) && !matches_s) begin
          state_nxt_s = RAMP;
        end else if (accept_s || stop) begin
          state_nxt_s = settled_s;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RAMP: begin
        if (accept_s) begin
          // The new command replaces the old target; no step this cycle.
          if (matches_s) begin
            state_nxt_s = settled_s;
          end else begin
            state_nxt_s = RAMP;
          end
        end else if (reverse_wait_s) begin
          // Entered RAMP at zero duty with a reversal still pending.
          state_nxt_s    = DEAD;
          dead_cnt_nxt_s = {DT_W{1'b0}};
        end else if (tick_s) begin
          duty_nxt_s = stepped_s;
          if ((stepped_s == {DUTY_W{1'b0}}) && (t_dir_nxt_s != pwm_dir_r)) begin
            state_nxt_s    = DEAD;
            dead_cnt_nxt_s = {DT_W{1'b0}};
          end else if ((stepped_s == t_duty_nxt_s) && (t_dir_nxt_s == pwm_dir_r)) begin
            state_nxt_s = settled_s;
          end else begin
            state_nxt_s = RAMP;
          end
        end else if (matches_s) begin
          state_nxt_s = settled_s;
        end else begin
          state_nxt_s = RAMP;
        end
      end
      DEAD: begin
        if (accept_s) begin
          dead_cnt_nxt_s = {DT_W{1'b0}};
          if (matches_s) begin
            state_nxt_s = settled_s;
          end else begin
            state_nxt_s = RAMP;
          end
        end else if (dead_cnt_r >= dt_last_s) begin
          // The flip happens here, so RAMP restarts with the directions equal.
          dir_nxt_s      = t_dir_nxt_s;
          state_nxt_s    = RAMP;
          dead_cnt_nxt_s = {DT_W{1'b0}};
        end else begin
          dead_cnt_nxt_s = dead_cnt_r + {{(DT_W-1){1'b0}}, 1'b1};
        end
      end
`ifdef MOTOR_RAMP_FAULT_EN
      FAULT: begin
        duty_nxt_s = {DUTY_W{1'b0}};
        if (fault_clr) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FAULT;
        end
      end
`endif
      default: begin
        state_nxt_s    = IDLE;
        duty_nxt_s     = {DUTY_W{1'b0}};
        dead_cnt_nxt_s = {DT_W{1'b0}};
      end
    endcase
`ifdef MOTOR_RAMP_FAULT_EN
    end
`endif
  end

  // State, target and every output are registered from the next-state values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r       <= IDLE;
      pwm_duty_r    <= {DUTY_W{1'b0}};
      pwm_dir_r     <= 1'b0;
      target_duty_r <= {DUTY_W{1'b0}};
      target_dir_r  <= 1'b0;
      dead_cnt_r    <= {DT_W{1'b0}};
      pwm_en_r      <= 1'b0;
      busy_r        <= 1'b0;
      at_target_r   <= 1'b1;
      cmd_ready_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pwm_duty_r    <= duty_nxt_s;
      pwm_dir_r     <= dir_nxt_s;
      target_duty_r <= t_duty_nxt_s;
      target_dir_r  <= t_dir_nxt_s;
      dead_cnt_r    <= dead_cnt_nxt_s;
      pwm_en_r      <= (duty_nxt_s != {DUTY_W{1'b0}}) && (state_nxt_s != DEAD);
      busy_r        <= (state_nxt_s == RAMP) || (state_nxt_s == DEAD);
      at_target_r   <= (duty_nxt_s == t_duty_nxt_s) && (dir_nxt_s == t_dir_nxt_s);
`ifdef MOTOR_RAMP_FAULT_EN
      cmd_ready_r   <= (state_nxt_s != FAULT);
`else
      cmd_ready_r   <= 1'b1;
`endif
    end
  end

`ifdef MOTOR_RAMP_FAULT_EN
  logic fault_flag_r;

  // Fault flag follows the latched FAULT state.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      fault_flag_r <= 1'b0;
    end else begin
      fault_flag_r <= (state_nxt_s == FAULT);
    end
  end

  assign fault_flag = fault_flag_r;
`else
  assign fault_flag = 1'b0;
`endif

  assign cmd_if.cmd_ready = cmd_ready_r;
  assign pwm_duty         = pwm_duty_r;
  assign pwm_dir          = pwm_dir_r;
  assign pwm_en           = pwm_en_r;
  assign busy             = busy_r;
  assign at_target        = at_target_r;

endmodule

// File: doc/motor_ramp_sequencer.md
# motor_ramp_sequencer

Command sequencer that sits between the MotorDriver AXI4-Lite register bank and the PWM core. It accepts target duty/direction commands and slews the applied PWM duty toward the target in fixed steps at a programmable rate. It inserts a zero-duty dead time before any direction reversal, and forces the output off on a fault.

## Interface
- DUTY_W, 16, width of duty values and step size
- PRESC_W, 16, width of step-period prescaler
- DT_W, 8, width of dead-time counter
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  new command offered
- cmd_ready  out  1  command can be accepted
- cmd_duty  in  DUTY_W  target duty magnitude
- cmd_dir  in  1  target direction
- stop  in  1  ramp to zero duty, current direction kept
- step_size  in  DUTY_W  duty change per step; 0 = jump directly to target
- step_period  in  PRESC_W  ACLK cycles per step; 0 treated as 1
- dead_time  in  DT_W  cycles held at zero/disabled before direction flip
- fault  in  1  external fault (MOTOR_RAMP_FAULT_EN only)
- fault_clr  in  1  clear latched fault (MOTOR_RAMP_FAULT_EN only)
- pwm_duty  out  DUTY_W  applied duty to PWM core
- pwm_dir  out  1  applied direction
- pwm_en  out  1  PWM output enable
- busy  out  1  ramp or dead time in progress
- at_target  out  1  applied duty and direction equal the target
- fault_flag  out  1  fault latched

## Operation
- Reset values: pwm_duty=0, pwm_dir=0, pwm_en=0, busy=0, at_target=1, fault_flag=0, cmd_ready=0. Target is 0 with dir 0. State is IDLE. cmd_ready=1 from the first cycle after ARESET is released.
- States: IDLE, RAMP, DEAD, HOLD, FAULT.
- Accept: cmd_valid && cmd_ready registers target_duty/target_dir. Commands are accepted in every state except FAULT, and a new command replaces the old target mid-ramp. Accepting a command resets the prescaler and moves to RAMP, unless the command already equals the applied duty and direction.
- stop: sets target_duty=0 and keeps target_dir. When stop and an accepted cmd occur in the same cycle, stop wins and the cmd is dropped.
- Effective goal: if target_dir != pwm_dir and pwm_duty != 0, the goal is 0. Otherwise the goal is target_duty.
- RAMP, on each prescaler tick, pwm_duty moves toward the goal by step_size and saturates at the goal without overshoot. Arithmetic is done in DUTY_W+1 bits so there is no wrap at full scale. When step_size=0, the duty is set to the goal on the first tick.
- When pwm_duty reaches 0 and target_dir != pwm_dir, the block enters DEAD. DEAD holds pwm_en=0 for max(dead_time,1) cycles. pwm_dir then toggles and the block returns to RAMP with the prescaler reset.
- When the goal is reached with dir matching: HOLD if target_duty != 0, else IDLE.
- pwm_en = (pwm_duty != 0) && state ∉ {DEAD, FAULT}.
- busy = state ∈ {RAMP, DEAD}.
- at_target = (pwm_duty == target_duty) && (pwm_dir == target_dir).
- Any change to step_period, step_size or dead_time mid-operation takes effect at the next tick or count compare. It does not restart the sequence.

## Timing
- Prescaler counts 0..max(step_period,1)-1 while in RAMP and ticks at the terminal count.
- The first duty change is visible step_period cycles after the acceptance edge (1 cycle if step_period ≤ 1).
- All outputs are registered; no combinational path from inputs to outputs.
- A fault asserted in cycle k gives pwm_duty=0, pwm_en=0 and fault_flag=1 after edge k.
- ARESET mid-ramp or mid-dead-time returns every output to its reset value on the next edge.

## Configuration
- MOTOR_RAMP_FAULT_EN defined:
  - fault/fault_clr ports exist and the FAULT state is reachable from any state.
  - FAULT forces duty 0, en 0, cmd_ready 0 and target_duty 0.
  - The block leaves FAULT only on fault_clr with fault low, going to IDLE with pwm_dir unchanged.
  - fault has priority over stop and cmd.
- MOTOR_RAMP_FAULT_EN not defined: fault ports are absent, the FAULT state is not generated and fault_flag is tied to 0.

## Structure
- Package motor_ramp_pkg holds:
  - the state enum (IDLE, RAMP, DEAD, HOLD, FAULT);
  - default width constants DUTY_W/PRESC_W/DT_W;
  - the duty-step saturating helper function.
- Sub-module motor_ramp_prescaler (clear input, period input, tick output) provides the step tick.

## Test plan
- Ramp up: step_size=100, step_period=4, cmd duty=1000, dir=0 -> duty rises by 100 every 4 cycles, reaches 1000 after 40 cycles; at_target=1, state HOLD.
- Saturation: step_size=300, target 1000 from 0 -> sequence 300, 600, 900, 1000 with no overshoot. Repeat at DUTY_W max, target 0xFFFF with step 0x8000 -> 0x8000, 0xFFFF with no wrap.
- Reversal: at duty 500 dir 0, cmd duty=500 dir=1, step 250, dead_time=10 -> duty 250, then 0; pwm_en low for 10 cycles; pwm_dir=1; then duty 250, 500.
- Stop vs cmd: stop and a cmd with duty=800 in the same cycle at duty 400 -> cmd dropped, ramps to 0, IDLE, pwm_en=0.
- Jump mode: step_size=0, step_period=0, cmd duty=700 -> pwm_duty=700 one cycle after acceptance.
- Fault (MOTOR_RAMP_FAULT_EN): fault pulse during ramp at duty 600 -> next edge duty 0, en 0, fault_flag 1, cmd_ready 0. A cmd while faulted is ignored. fault_clr -> IDLE with cmd_ready=1.
